// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: byte delivery channel from the PS/2 receiver to its consumer.
// The receiver drives the byte and its error pulses. The consumer drives byte_ready.
interface ps2_host_rx_if;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output byte_valid,
    output byte_data,
    output parity_error,
    output frame_error,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  parity_error,
    input  frame_error,
    output byte_ready
  );
endinterface

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 keyboard receive front-end.
// - Synchronises and de-glitches the PS/2 pad inputs.
// - Frames 11-bit device-to-host transfers and checks odd parity.
// - Delivers bytes over a valid/ready channel.
// - Holds the PS/2 clock low while no further byte can be stored.
// Optional macro PS2_HOST_RX_FIFO_EN replaces the single holding register with a 4-entry FIFO.
module ps2_host_rx #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_in__clk,
  input  logic          ps2_in__data,
  output logic          ps2_out__clk,
  output logic          ps2_out__data,
  ps2_host_rx_if.master bus
);

  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input conditioning
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_s, data_s;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  // Framing
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           perr_d, ferr_d;
  logic           perr_q, ferr_q;
  logic           push;

  // Storage
  logic full, pop, can_push;
  logic oclk_q;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Two-flop synchronisers on both pads; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_in__clk};
      data_sync_q <= {data_sync_q[0], ps2_in__data};
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_CYCLES differing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_CYCLES - 1)) begin
        filt_d = clk_s;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame decoder next-state, error classification and timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = to_cnt_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;

    unique case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (fall) begin
          if (!data_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, parity_q})) begin
            // Odd parity over data plus parity bit must give XOR = 1.
            perr_d = 1'b1;
          end else if (!can_push) begin
            // Device ignored the inhibit: drop the new byte.
            ferr_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
        state_d  = StIdle;
        ferr_d   = 1'b1;
        to_cnt_d = '0;
        shift_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Frame decoder state and registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign pop      = bus.byte_valid && bus.byte_ready;
  // A pop in the same cycle frees the slot the new byte needs.
  assign can_push = !full || pop;

`ifdef PS2_HOST_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;

  assign full           = (count_q == 3'd4);
  assign bus.byte_valid = (count_q != 3'd0);
  assign bus.byte_data  = mem_q[rd_ptr_q];

  // Four-entry FIFO; 2-bit pointers wrap naturally from 3 to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop) count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
    end
  end
`else
  logic [7:0] hold_q;
  logic       valid_q;

  assign full           = valid_q;
  assign bus.byte_valid = valid_q;
  assign bus.byte_data  = hold_q;

  // Single holding register; a push in the accept cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  // Inhibit only between frames, so a device transfer is never cut short.
  always_ff @(posedge clk) begin
    if (reset) oclk_q <= 1'b1;
    else       oclk_q <= !(full && (state_q == StIdle));
  end

  assign ps2_out__clk     = oclk_q;
  assign ps2_out__data    = 1'b1;
  assign bus.parity_error = perr_q;
  assign bus.frame_error  = ferr_q;

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- PS/2 keyboard receive front-end on the 50 MHz system clock.
- Consumes the open-drain PS/2 pad samples (ps2_in__clk, ps2_in__data) and produces the matching drive controls (ps2_out__clk, ps2_out__data).
- Delivers validated scan-code bytes over a valid/ready interface to the keyboard matrix emulation inside the BBC micro core.
- Inhibits the device by holding PS/2 clock low whenever it cannot accept another byte.

Parameters:
- FILTER_CYCLES, 8: consecutive identical synchronised samples of ps2_in__clk required before the filtered clock changes state.
- TIMEOUT_CYCLES, 50000: clk cycles (1 ms) without a filtered falling edge, mid-frame, before the frame is abandoned.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous active-high reset
- ps2_in__clk  input  1  raw PS/2 clock pad level (asynchronous)
- ps2_in__data  input  1  raw PS/2 data pad level (asynchronous)
- ps2_out__clk  output  1  1 = release clock pad (high-Z), 0 = pull low (inhibit)
- ps2_out__data  output  1  1 = release data pad; constant 1 in this block (receive only)
- byte_valid  output  1  byte_data holds a received byte
- byte_ready  input  1  consumer accepts the byte when byte_valid && byte_ready at a clk edge
- byte_data  output  8  received byte, LSB first on the wire
- parity_error  output  1  one-cycle pulse: frame discarded because of bad odd parity
- frame_error  output  1  one-cycle pulse: frame discarded because of bad start bit, bad stop bit or timeout

Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Input conditioning:
  - Each pad input passes through a 2-flop synchroniser.
  - Synchronised clock feeds a filter counter; the filtered clock toggles only after FILTER_CYCLES equal samples differing from its current value.
  - Filter counter resets on any sample equal to the current filtered value.
  - Falling edge of the filtered clock produces a one-cycle strobe fall.
  - The data bit is the synchronised data level sampled in the same cycle as fall.
- Reset values:
  - Filtered clock = 1.
  - State = IDLE.
  - byte_valid = 0, byte_data = 0x00, parity_error = 0, frame_error = 0.
  - ps2_out__clk = 1, ps2_out__data = 1.
  - All counters = 0.
- FSM states:
  - IDLE: on fall with data = 0 (start bit), go to DATA with bit count 0 and timeout cleared. On fall with data = 1, pulse frame_error and stay in IDLE.
  - DATA: on each fall, shift data into bit 7 of the shift register (LSB first). After the 8th bit go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, check the stop bit and parity, then go to IDLE.
    - Stop bit = 1 and odd parity over data+parity correct: deliver the byte.
    - Stop bit = 0: pulse frame_error.
    - Parity wrong (stop bit good): pulse parity_error only.
- Timeout:
  - In DATA, PARITY and STOP, the timeout counter increments every cycle without fall and clears on fall.
  - Reaching TIMEOUT_CYCLES-1: pulse frame_error, go to IDLE, discard partial data.
- Delivery:
  - Byte written to the holding register.
  - byte_valid asserts on the cycle after the stop-bit fall (latency 1 clk from the stop-bit fall).
  - byte_valid and byte_data are held stable until accepted.
  - Accept and new delivery in the same cycle: the register takes the new byte and byte_valid stays 1.
- Inhibit:
  - ps2_out__clk = 0 while the holding storage is full and the FSM is in IDLE; otherwise 1.
  - Registered; changes one cycle after the condition changes.
  - Never asserted mid-frame.
- Overrun:
  - Storage full at the stop bit (device ignored the inhibit): the new byte is dropped and frame_error pulses; the stored byte is unchanged.
- Error pulse width: parity_error and frame_error are exactly 1 cycle and never assert together.
- Reset mid-frame: next cycle is fully in reset state; the partial frame is lost and no error pulse is generated.

Optional Feature:
- Macro: PS2_HOST_RX_FIFO_EN.
- Defined:
  - Holding register replaced by a 4-entry FIFO (2-bit pointers plus count 0..4).
  - byte_valid = count != 0; byte_data = head entry.
  - "Full" means count = 4.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Wrap-around: pointers wrap from 3 to 0.
- Undefined: single-entry holding register as described above; "full" means byte_valid = 1.

Test Plan:
- Clean frame:
  - Stimulus: send 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), 12.5 kHz PS/2 clock, byte_ready = 1.
  - Response: byte_valid for 1 cycle, byte_data = 0x1C, no error pulses.
- Parity error:
  - Stimulus: send 0xF0 with parity bit 0 (correct parity is 1).
  - Response: parity_error pulses once; byte_valid stays 0.
- Timeout:
  - Stimulus: 4 data bits, then clock held high for 1.1 ms.
  - Response: frame_error pulses within 50000 cycles of the last fall; a following frame 0x5A is received correctly.
- Back-pressure:
  - Stimulus: byte_ready = 0; send 0x12.
  - Response: ps2_out__clk = 0 within 2 cycles of byte_valid, with byte_data = 0x12.
  - Then raise byte_ready: byte consumed and ps2_out__clk = 1.
  - With the FIFO macro: 4 bytes are stored before inhibit, then read back in order 0x12, 0x34, 0x56, 0x78.
- Glitch rejection:
  - Stimulus: 3-cycle low glitch on ps2_in__clk while idle.
  - Response: no state change and no error pulse.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle after 5 bits.
  - Response: all outputs return to reset values; the next full frame 0x29 is delivered correctly.
